// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the score display path.
//   - Active-low seven-segment codes {g,f,e,d,c,b,a}: SEG_DIGIT[0:9], SEG_BLANK, SEG_DASH
//   - Conversion FSM state type (IDLE, SHIFT, COMMIT)
//   - BCD nibble type and the shift-add-3 nibble correction helper
package display_pkg;

  typedef logic [3:0] bcd_nibble_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Double-dabble correction: a nibble of 5 or more would carry past 9
  // after the next left shift, so pre-add 3.
  function automatic bcd_nibble_t add3_adjust(input bcd_nibble_t n);
    return (n >= 4'd5) ? 4'(n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD nibble to active-low seven-segment decoder.
// Ports:
//   digit  in  4  BCD nibble; 10..15 decode to blank
//   blank  in  1  force blank (leading-zero suppression)
//   dash   in  1  force dash (overflow); overrides blank
//   seg_c  out 7  segments {g,f,e,d,c,b,a}, active-low, combinational
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (dash) begin
      seg_c = SEG_DASH;
    end else if (!blank) begin
      for (int i = 0; i < 10; i++) begin
        if (digit == 4'(i)) seg_c = SEG_DIGIT[i];
      end
    end
  end

endmodule

// File: rtl/score_display_driver.sv
// score_display_driver: converts the processor's binary score to BCD with a
// sequential shift-add-3 engine and scans it onto common-anode 7-seg digits.
// Optional macro LEADING_ZERO_BLANK_EN: blank digits above the most
// significant nonzero digit (digit 0 always shown).
// Ports:
//   clock     in   1             system clock
//   reset     in   1             synchronous active-high reset
//   score_in  in   32            binary score
//   seg       out  7             segments {g,f,e,d,c,b,a}, active-low
//   an        out  NUM_DIGITS    digit anodes, active-low one-hot
//   bcd_out   out  4*NUM_DIGITS  committed BCD, digit 0 at [3:0]
//   busy      out  1             conversion in progress
//   overflow  out  1             committed value exceeds display range
module score_display_driver
  import display_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 16,
  parameter int unsigned NUM_DIGITS  = 5,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             score_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    busy,
  output logic                    overflow
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  conv_state_t          state;
  logic [31:0]          capture;
  logic [31:0]          last_captured;
  logic [IN_WIDTH-1:0]  shift_reg;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     adjusted;
  logic [CNT_W-1:0]     bit_cnt;
  logic [REF_W-1:0]     refresh_cnt;
  logic [IDX_W-1:0]     digit_idx;
  logic [3:0]           cur_digit;
  logic                 blank;
  logic [6:0]           seg_c;

  // Add-3 correction applied to every scratch nibble before each shift.
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      adjusted[4*i +: 4] = add3_adjust(scratch[4*i +: 4]);
    end
  end

  // Conversion FSM: capture on change, IN_WIDTH shift cycles, one commit cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      capture       <= '0;
      last_captured <= '0;
      shift_reg     <= '0;
      scratch       <= '0;
      bit_cnt       <= '0;
      bcd_out       <= '0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (score_in != last_captured) begin
            capture       <= score_in;
            last_captured <= score_in;
            shift_reg     <= score_in[IN_WIDTH-1:0];
            scratch       <= '0;
            bit_cnt       <= '0;
            busy          <= 1'b1;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          // Top bit of the adjusted scratch cannot be set for legal ranges.
          scratch   <= BCD_W'({adjusted, shift_reg[IN_WIDTH-1]});
          shift_reg <= shift_reg << 1;
          bit_cnt   <= CNT_W'(bit_cnt + 1'b1);
          if (bit_cnt == CNT_W'(IN_WIDTH - 1)) state <= COMMIT;
        end
        COMMIT: begin
          bcd_out  <= scratch;
          overflow <= (capture >> IN_WIDTH) != 32'd0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Select the committed nibble for the digit currently being scanned.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (digit_idx == IDX_W'(i)) cur_digit = bcd_out[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // True when this digit and every digit above it are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if ((IDX_W'(i) >= digit_idx) && (bcd_out[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
    end
  end

  assign blank = (digit_idx != '0) && upper_zero;
`else
  assign blank = 1'b0;
`endif

  bcd_to_seg u_bcd_to_seg (
    .digit (cur_digit),
    .blank (blank),
    .dash  (overflow),
    .seg_c (seg_c)
  );

  // Refresh counter and digit scan; an/seg registered together.
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      an          <= '1;
      seg         <= SEG_BLANK;
    end else begin
      if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : IDX_W'(digit_idx + 1'b1);
      end else begin
        refresh_cnt <= REF_W'(refresh_cnt + 1'b1);
      end
      an  <= ~(NUM_DIGITS'(1) << digit_idx);
      seg <= seg_c;
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// tb_score_display_driver: directed plus random checks of score_display_driver
// against a decimal-arithmetic reference model.
module tb_score_display_driver;

  localparam int unsigned ND = 5;
  localparam int unsigned RD = 4;
  localparam int unsigned IW = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [31:0]     score_in;
  logic [6:0]      seg;
  logic [ND-1:0]   an;
  logic [4*ND-1:0] bcd_out;
  logic            busy;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clock = ~clock;

  score_display_driver #(
    .IN_WIDTH    (IW),
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .score_in (score_in),
    .seg      (seg),
    .an       (an),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected BCD: decimal digits of the low IW bits.
  function automatic logic [4*ND-1:0] ref_bcd(input logic [31:0] v);
    logic [4*ND-1:0] r;
    int unsigned x;
    x = v & 32'h0000_FFFF;
    r = '0;
    for (int i = 0; i < int'(ND); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Expected segment pattern for digit i of committed value v.
  function automatic logic [6:0] ref_seg(input logic [31:0] v, input int i);
    int unsigned x;
    int unsigned p;
    x = v & 32'h0000_FFFF;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (v > 32'h0000_FFFF) return 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
    if (i != 0 && x < p) return 7'h7F;
`endif
    return seg_tab[(x / p) % 10];
  endfunction

  function automatic int an_index(input logic [ND-1:0] a);
    int idx;
    int zeros;
    idx = -1;
    zeros = 0;
    for (int i = 0; i < int'(ND); i++) begin
      if (a[i] === 1'b0) begin
        idx = i;
        zeros++;
      end
    end
    return (zeros == 1) ? idx : -1;
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Called right after score_in changed (or reset released) at a negedge.
  task automatic wait_conv(input logic [31:0] v, input logic [4*ND-1:0] prev_bcd);
    for (int k = 1; k <= int'(IW) + 2; k++) begin
      step();
      if (k <= int'(IW) + 1) begin
        chk("busy_high", 32'(busy), 32'd1);
        chk("bcd_hold", 32'(bcd_out), 32'(prev_bcd));
      end else begin
        chk("busy_done", 32'(busy), 32'd0);
        chk("bcd_commit", 32'(bcd_out), 32'(ref_bcd(v)));
        chk("overflow", 32'(overflow), 32'((v >> IW) != 0));
      end
    end
  endtask

  task automatic check_display(input logic [31:0] v, input int cycles);
    int idx;
    for (int c = 0; c < cycles; c++) begin
      step();
      idx = an_index(an);
      chk("an_onehot", 32'(idx >= 0), 32'd1);
      if (idx >= 0) chk($sformatf("seg_d%0d", idx), 32'(seg), 32'(ref_seg(v, idx)));
    end
  endtask

  task automatic check_scan_timing();
    logic [ND-1:0] a0;
    int n;
    int prev;
    int len;
    a0 = an;
    n = 0;
    while (an === a0 && n < int'(4 * RD * ND)) begin
      step();
      n++;
    end
    chk("scan_start", 32'(an !== a0), 32'd1);
    for (int r = 0; r < int'(2 * ND); r++) begin
      a0 = an;
      prev = an_index(an);
      len = 0;
      while (an === a0 && len < int'(3 * RD)) begin
        step();
        len++;
      end
      chk("run_len", 32'(len), 32'(RD));
      chk("next_digit", 32'(an_index(an)), 32'((prev + 1) % int'(ND)));
    end
  endtask

  initial begin
    logic [31:0] last_val;
    logic [31:0] v;

    reset = 1'b1;
    score_in = 32'd0;
    @(negedge clock);
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'h1F);

    // Unchanged zero score: no conversion ever starts.
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_bcd", 32'(bcd_out), 32'd0);
    end
    check_display(32'd0, int'(RD * ND));
    check_scan_timing();

    // Directed values, including the top of range and overflow.
    score_in = 32'd12345;
    wait_conv(32'd12345, ref_bcd(32'd0));
    check_display(32'd12345, int'(RD * ND) + 2);

    score_in = 32'd65535;
    wait_conv(32'd65535, ref_bcd(32'd12345));
    check_display(32'd65535, int'(RD * ND) + 2);

    score_in = 32'h0001_0000;
    wait_conv(32'h0001_0000, ref_bcd(32'd65535));
    check_display(32'h0001_0000, int'(RD * ND) + 2);

    // Changes while busy: 7 commits, 8 is skipped, 9 commits next.
    score_in = 32'd7;
    for (int k = 1; k <= 2 * (int'(IW) + 2); k++) begin
      step();
      if (k == 3) score_in = 32'd8;
      if (k == 6) score_in = 32'd9;
      chk("never_eight", 32'(bcd_out == ref_bcd(32'd8)), 32'd0);
      if (k == int'(IW) + 2) begin
        chk("coal_first", 32'(bcd_out), 32'(ref_bcd(32'd7)));
        chk("coal_first_idle", 32'(busy), 32'd0);
        chk("coal_first_ovf", 32'(overflow), 32'd0);
      end
      if (k == int'(IW) + 3) chk("coal_restart", 32'(busy), 32'd1);
      if (k == 2 * (int'(IW) + 2)) begin
        chk("coal_second", 32'(bcd_out), 32'(ref_bcd(32'd9)));
        chk("coal_second_idle", 32'(busy), 32'd0);
      end
    end
    for (int c = 0; c < 20; c++) begin
      step();
      chk("coal_quiet", 32'(busy), 32'd0);
    end

    // Reset in the middle of SHIFT aborts; value reconverts afterwards.
    score_in = 32'd4321;
    repeat (5) step();
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    chk("abort_an", 32'(an), 32'h1F);
    chk("abort_seg", 32'(seg), 32'h7F);
    chk("abort_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    wait_conv(32'd4321, ref_bcd(32'd0));
    check_display(32'd4321, int'(RD * ND) + 2);
    last_val = 32'd4321;

    // Random scores, mostly in range, some overflowing.
    for (int r = 0; r < 8; r++) begin
      v = $urandom;
      if ($urandom_range(0, 3) != 0) v = v & 32'h0000_FFFF;
      if ($urandom_range(0, 3) == 0) v = v % 32'd100;
      if (v == last_val) v = v ^ 32'd1;
      score_in = v;
      wait_conv(v, ref_bcd(last_val));
      check_display(v, int'(RD * ND) + 2);
      last_val = v;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
